// File: rtl/arbitro_rr_4x1.sv
// Round-robin 4:1 arbiter with hold timeout, driving a shared N-bit
// output through an internal mux4x1 selected by the registered owner.

module mux4x1 #(
    parameter int N = 7
) (
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic [N-1:0] D3,
    input  logic [1:0]   SEL,
    output logic [N-1:0] Y
);

    always_comb begin
        Y = D0;
        unique case (SEL)
            2'd0: Y = D0;
            2'd1: Y = D1;
            2'd2: Y = D2;
            2'd3: Y = D3;
        endcase
    end

endmodule

module arbitro_rr_4x1 #(
    parameter int N        = 7,
    parameter int MAX_HOLD = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic [N-1:0] D3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic         valid,
    output logic [N-1:0] OUT,
    output logic         preempt
);

    localparam int CW = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q;
    logic [1:0]    owner_q;
    logic [1:0]    ptr_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    gnt_q;
    logic [1:0]    sel_q;
    logic          preempt_q;

    logic [1:0]    win_d;
    logic [3:0]    win_oh_d;
    logic          found_d;
    logic [1:0]    idx_d;
    logic [N-1:0]  mux_y;

    // First requester found scanning upward from ptr, wrapping mod 4.
    always_comb begin
        win_d   = ptr_q;
        found_d = 1'b0;
        idx_d   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx_d = ptr_q + 2'(k);
            if (!found_d && req[idx_d]) begin
                win_d   = idx_d;
                found_d = 1'b1;
            end
        end
        win_oh_d = 4'b0001 << win_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= GRANT;
                        owner_q <= win_d;
                        sel_q   <= win_d;
                        gnt_q   <= win_oh_d;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (!req[owner_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        ptr_q   <= owner_q + 2'd1;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q   <= IDLE;
                        gnt_q     <= 4'b0000;
                        ptr_q     <= owner_q + 2'd1;
                        cnt_q     <= '0;
                        preempt_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mux4x1 #(
        .N(N)
    ) u_mux (
        .D0  (D0),
        .D1  (D1),
        .D2  (D2),
        .D3  (D3),
        .SEL (sel_q),
        .Y   (mux_y)
    );

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign valid   = |gnt_q;
    assign preempt = preempt_q;
    assign OUT     = valid ? mux_y : '0;

endmodule

// File: tb/tb_arbitro_rr_4x1.sv
// Scoreboard bench for arbitro_rr_4x1: directed phases push
// cycle-stamped expected outputs; a negedge monitor pops and compares.

module tb_arbitro_rr_4x1;

    localparam int M = 8;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic [6:0] D0, D1, D2, D3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [6:0] OUT;
    logic       preempt;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic [6:0]  out;
        logic        pre;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;
    int unsigned cyc = 0;
    int unsigned e0;
    logic [6:0] dv [4];

    arbitro_rr_4x1 #(.N(7), .MAX_HOLD(M)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .D0      (D0),
        .D1      (D1),
        .D2      (D2),
        .D3      (D3),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .OUT     (OUT),
        .preempt (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n && (valid || preempt)) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out cyc=%0d gnt=%b sel=%0d out=%h pre=%b, required no output",
                         cyc, gnt, sel, OUT, preempt);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.gnt != gnt || e.sel != sel ||
                    e.out != OUT || e.pre != preempt || valid != (|e.gnt)) begin
                    fails++;
                    $display("FAIL grant_seq got cyc=%0d gnt=%b sel=%0d out=%h pre=%b valid=%b required cyc=%0d gnt=%b sel=%0d out=%h pre=%b",
                             cyc, gnt, sel, OUT, preempt, valid,
                             e.cyc, e.gnt, e.sel, e.out, e.pre);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int unsigned c, input logic [3:0] g,
                        input logic [1:0] s, input logic [6:0] o,
                        input logic p);
        q.push_back('{c, g, s, o, p});
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] req_v);
        checks++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s got %h required %h", name, act, req_v);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, {4'b0, gnt}, 8'h00);
        chk({tag, "_sel"}, {6'b0, sel}, 8'h00);
        chk({tag, "_valid"}, {7'b0, valid}, 8'h00);
        chk({tag, "_out"}, {1'b0, OUT}, 8'h00);
        chk({tag, "_preempt"}, {7'b0, preempt}, 8'h00);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk_zero(tag);
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        repeat (3) step();
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing got %0d outstanding required 0", tag, q.size());
        end
        q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        req = 4'b0000;
        D0 = 7'h11; D1 = 7'h22; D2 = 7'h5A; D3 = 7'h6C;
        dv[0] = 7'h11; dv[1] = 7'h22; dv[2] = 7'h5A; dv[3] = 7'h6C;
        #1;
        chk_zero("reset_init");
        step();
        step();
        reset_n = 1'b1;

        // single requester, data change mid-grant, then scan from 3
        step(); e0 = cyc; req = 4'b0100;
        push(e0 + 1, 4'b0100, 2'd2, 7'h5A, 1'b0);
        push(e0 + 2, 4'b0100, 2'd2, 7'h33, 1'b0);
        push(e0 + 3, 4'b0100, 2'd2, 7'h33, 1'b0);
        push(e0 + 5, 4'b1000, 2'd3, 7'h6C, 1'b0);
        push(e0 + 7, 4'b0001, 2'd0, 7'h11, 1'b0);
        step(); step(); D2 = 7'h33;
        step(); req = 4'b0000;
        step(); req = 4'b1001;
        step(); req = 4'b0001;
        step(); step(); req = 4'b0000;
        drain("single");

        // async reset in the middle of a grant to requester 2
        D2 = 7'h5A;
        step(); e0 = cyc; req = 4'b0100;
        push(e0 + 1, 4'b0100, 2'd2, 7'h5A, 1'b0);
        step();
        @(negedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk_zero("reset_midgrant");
        req = 4'b0000;
        step(); step();
        reset_n = 1'b1;
        drain("reset");

        // round robin 0,1,2,3,0 with dead cycles
        step(); e0 = cyc; req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push(e0 + 1 + 3 * k, 4'b0001 << k, 2'(k), dv[k], 1'b0);
            push(e0 + 2 + 3 * k, 4'b0001 << k, 2'(k), dv[k], 1'b0);
        end
        push(e0 + 13, 4'b0001, 2'd0, 7'h11, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(); step(); req[k] = 1'b0;
            step(); req = 4'b1111;
        end
        step(); req = 4'b0000;
        drain("rr");

        // timeout with two contenders
        do_reset("reset_phase");
        step(); e0 = cyc; req = 4'b0011;
        for (int i = 0; i < M; i++)
            push(e0 + 1 + i, 4'b0001, 2'd0, 7'h11, 1'b0);
        push(e0 + M + 1, 4'b0000, 2'd0, 7'h00, 1'b1);
        for (int i = 0; i < M; i++)
            push(e0 + M + 2 + i, 4'b0010, 2'd1, 7'h22, 1'b0);
        push(e0 + 2 * M + 2, 4'b0000, 2'd1, 7'h00, 1'b1);
        push(e0 + 2 * M + 3, 4'b0001, 2'd0, 7'h11, 1'b0);
        repeat (2 * M + 3) step();
        req = 4'b0000;
        drain("timeout");

        // sole requester still gets preempted
        step(); e0 = cyc; req = 4'b1000;
        for (int i = 0; i < M; i++)
            push(e0 + 1 + i, 4'b1000, 2'd3, 7'h6C, 1'b0);
        push(e0 + M + 1, 4'b0000, 2'd3, 7'h00, 1'b1);
        for (int i = 0; i < M; i++)
            push(e0 + M + 2 + i, 4'b1000, 2'd3, 7'h6C, 1'b0);
        push(e0 + 2 * M + 2, 4'b0000, 2'd3, 7'h00, 1'b1);
        push(e0 + 2 * M + 3, 4'b1000, 2'd3, 7'h6C, 1'b0);
        push(e0 + 2 * M + 4, 4'b1000, 2'd3, 7'h6C, 1'b0);
        repeat (20) step();
        req = 4'b0000;
        drain("sole");

        // owner 1 drops as 0 and 3 rise: 3 then 0
        step(); e0 = cyc; req = 4'b0010;
        push(e0 + 1, 4'b0010, 2'd1, 7'h22, 1'b0);
        push(e0 + 2, 4'b0010, 2'd1, 7'h22, 1'b0);
        push(e0 + 4, 4'b1000, 2'd3, 7'h6C, 1'b0);
        push(e0 + 6, 4'b0001, 2'd0, 7'h11, 1'b0);
        step(); step(); req = 4'b1001;
        step(); step(); req = 4'b0001;
        step(); step(); req = 4'b0000;
        drain("simul");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
